// File: rtl/onchip_mem_pattern_master.sv
// Avalon-MM pattern master for the on-chip RAM s1 port: fills a word window
// with seed+i, or reads it back and counts mismatches against that pattern.
module onchip_mem_pattern_master #(
  parameter int ADDR_W       = 11,
  parameter int DATA_W       = 16,
  parameter int READ_LATENCY = 1
) (
  input  logic                clk_clk,
  input  logic                reset_reset_n,
  input  logic                start,
  input  logic                mode,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [ADDR_W:0]     length,
  input  logic [DATA_W-1:0]   seed,
  input  logic                abort,
  output logic                busy,
  output logic                done,
  output logic                aborted,
  output logic [ADDR_W:0]     error_count,
  output logic                first_err_valid,
  output logic [ADDR_W-1:0]   first_err_addr,
  output logic [ADDR_W-1:0]   m_address,
  output logic                m_clken,
  output logic                m_chipselect,
  output logic                m_write,
  output logic [DATA_W-1:0]   m_writedata,
  output logic [DATA_W/8-1:0] m_byteenable,
  input  logic [DATA_W-1:0]   m_readdata
);
  localparam int              RL    = READ_LATENCY;
  localparam logic [ADDR_W:0] ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] DEPTH = ONE << ADDR_W;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} state_e;

  state_e            state_q;
  logic              mode_q;      // 1 = VERIFY
  logic [ADDR_W:0]   remain_q;    // accesses still to issue after the current one
  logic              busy_q, done_q, aborted_q, fev_q;
  logic [ADDR_W:0]   err_cnt_q;
  logic [ADDR_W-1:0] fea_q, addr_q;
  logic              clken_q, cs_q, wr_q;
  logic [DATA_W-1:0] wdata_q;

  // Read-tracking pipeline: stage RL-1 lines up with m_readdata.
  logic [RL-1:0]     pv_q;
  logic [DATA_W-1:0] pexp_q  [RL];
  logic [ADDR_W-1:0] paddr_q [RL];

  logic [ADDR_W:0] len_clamped;
  logic            issue_rd, abort_now, mismatch, tail_busy;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    len_clamped = (length > DEPTH) ? DEPTH : length;
    issue_rd    = (state_q == ISSUE) && mode_q;
    abort_now   = abort && ((state_q == ISSUE) || (state_q == DRAIN));
    mismatch    = pv_q[RL-1] && !abort_now && (m_readdata != pexp_q[RL-1]);
    tail_busy   = 1'b0;
    for (int s = 0; s < RL-1; s++) tail_busy = tail_busy | pv_q[s];
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      pv_q <= '0;
    end else begin
      pv_q[0] <= issue_rd && !abort_now;
      for (int s = 1; s < RL; s++) pv_q[s] <= pv_q[s-1] && !abort_now;
    end
  end

  // NOTE: the expected-data/address stages are not reset; only their valid bits gate any use.
  always_ff @(posedge clk_clk) begin
    pexp_q[0]  <= wdata_q;
    paddr_q[0] <= addr_q;
    for (int s = 1; s < RL; s++) begin
      pexp_q[s]  <= pexp_q[s-1];
      paddr_q[s] <= paddr_q[s-1];
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q   <= IDLE;
      mode_q    <= 1'b0;
      remain_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      err_cnt_q <= '0;
      fev_q     <= 1'b0;
      fea_q     <= '0;
      addr_q    <= '0;
      clken_q   <= 1'b0;
      cs_q      <= 1'b0;
      wr_q      <= 1'b0;
      wdata_q   <= '0;
    end else begin
      done_q <= 1'b0;
      if (mismatch) begin
        if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + ONE;
        if (!fev_q) begin
          fev_q <= 1'b1;
          fea_q <= paddr_q[RL-1];
        end
      end
      unique case (state_q)
        IDLE: begin
          if (start) begin
            mode_q    <= mode;
            aborted_q <= 1'b0;
            err_cnt_q <= '0;
            fev_q     <= 1'b0;
            clken_q   <= 1'b1;
            if (len_clamped == '0) begin
              state_q <= FINISH;
              done_q  <= 1'b1;
            end else begin
              state_q  <= ISSUE;
              busy_q   <= 1'b1;
              cs_q     <= 1'b1;
              wr_q     <= !mode;
              addr_q   <= base_addr;
              wdata_q  <= seed;
              remain_q <= len_clamped - ONE;
            end
          end
        end
        ISSUE: begin
          if (abort || (remain_q == '0)) begin
            cs_q <= 1'b0;
            wr_q <= 1'b0;
            if (abort || !mode_q) begin
              state_q   <= FINISH;
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
              aborted_q <= abort;
            end else begin
              state_q <= DRAIN;
            end
          end else begin
            addr_q   <= addr_q + ADDR_W'(1);
            wdata_q  <= wdata_q + DATA_W'(1);
            remain_q <= remain_q - ONE;
          end
        end
        DRAIN: begin
          // The last outstanding read is compared on the edge that leaves DRAIN.
          if (abort || !tail_busy) begin
            state_q   <= FINISH;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            aborted_q <= abort;
          end
        end
        FINISH: begin
          state_q <= IDLE;
          clken_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign aborted         = aborted_q;
  assign error_count     = err_cnt_q;
  assign first_err_valid = fev_q;
  assign first_err_addr  = fea_q;
  assign m_address       = addr_q;
  assign m_clken         = clken_q;
  assign m_chipselect    = cs_q;
  assign m_write         = wr_q;
  assign m_writedata     = wdata_q;
  assign m_byteenable    = '1;

endmodule

// File: tb/tb_onchip_mem_pattern_master.sv
// Bench for onchip_mem_pattern_master: RAM model on s1, directed operations,
// and a per-cycle comparison against a closed-form timing/result model.
module tb_onchip_mem_pattern_master;
  localparam int AW    = 11;
  localparam int DW    = 16;
  localparam int RL    = 1;
  localparam int DEPTH = 2048;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          start = 1'b0, mode = 1'b0, abort = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   length = '0;
  logic [DW-1:0] seed = '0;
  logic          busy, done, aborted, first_err_valid;
  logic [AW:0]   error_count;
  logic [AW-1:0] first_err_addr, m_address;
  logic          m_clken, m_chipselect, m_write;
  logic [DW-1:0] m_writedata, m_readdata;
  logic [DW/8-1:0] m_byteenable;

  always #5 clk = ~clk;

  onchip_mem_pattern_master #(.ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(RL)) dut (
    .clk_clk(clk), .reset_reset_n(rst_n), .start(start), .mode(mode),
    .base_addr(base_addr), .length(length), .seed(seed), .abort(abort),
    .busy(busy), .done(done), .aborted(aborted), .error_count(error_count),
    .first_err_valid(first_err_valid), .first_err_addr(first_err_addr),
    .m_address(m_address), .m_clken(m_clken), .m_chipselect(m_chipselect),
    .m_write(m_write), .m_writedata(m_writedata), .m_byteenable(m_byteenable),
    .m_readdata(m_readdata)
  );

  int tests = 0, fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails <= 40) $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // s1 RAM model with READ_LATENCY-deep read path, plus a bench-side corrupt port.
  logic [DW-1:0] ram [DEPTH];
  logic [DW-1:0] rdp [RL];
  logic          corrupt_req = 1'b0;
  logic [AW-1:0] corrupt_addr = '0;
  logic [DW-1:0] corrupt_data = '0;

  always @(posedge clk) begin
    if (corrupt_req) ram[corrupt_addr] <= corrupt_data;
    else if (m_clken && m_chipselect && m_write) ram[m_address] <= m_writedata;
    if (m_clken) begin
      rdp[0] <= ram[m_address];
      for (int s = 1; s < RL; s++) rdp[s] <= rdp[s-1];
    end
  end
  assign m_readdata = rdp[RL-1];

  // Operation model: start cycle T, word count N, abort cycle A (0 = none).
  bit            op_valid = 1'b0;
  bit            op_mode;
  int            op_T, op_N, op_A;
  logic [AW-1:0] op_base;
  logic [DW-1:0] op_seed;
  bit            mm [DEPTH];
  logic [AW:0]   base_err = '0;
  bit            base_fev = 1'b0, base_ab = 1'b0;
  logic [AW-1:0] base_fea = '0;

  bit            e_busy, e_done, e_clken, e_cs, e_wr, e_ab, e_fev;
  logic [AW-1:0] e_addr, e_fea;
  logic [DW-1:0] e_wdata;
  logic [AW:0]   e_err;

  // Last cycle in which abort takes effect (ISSUE or DRAIN).
  function automatic int win_end();
    if (op_N == 0) return op_T;
    return op_mode ? op_T + op_N + RL : op_T + op_N;
  endfunction

  function automatic void model_eval(input int c);
    int  d, last, s;
    bit  ab;
    e_busy = 1'b0; e_done = 1'b0; e_clken = 1'b0; e_cs = 1'b0; e_wr = 1'b0;
    e_addr = '0; e_wdata = '0;
    e_err = base_err; e_fev = base_fev; e_fea = base_fea; e_ab = base_ab;
    if (!op_valid || c <= op_T) return;
    ab   = (op_A > op_T) && (op_A <= win_end());
    d    = ab ? op_A + 1 : win_end() + 1;
    last = op_T + op_N;
    if (ab && op_A < last) last = op_A;
    e_busy  = c < d;
    e_done  = c == d;
    e_clken = c <= d;
    e_ab    = ab && (c >= d);
    if (c <= last) begin
      e_cs    = 1'b1;
      e_wr    = !op_mode;
      e_addr  = op_base + AW'(c - op_T - 1);
      e_wdata = op_seed + DW'(c - op_T - 1);
    end
    e_err = '0;
    e_fev = 1'b0;
    for (int i = 0; i < op_N; i++) begin
      s = op_T + 1 + i + RL;  // edge at the end of this cycle samples word i
      if (s >= c) break;
      if (op_mode && mm[i] && (!ab || s < op_A)) begin
        if (!e_fev) e_fea = op_base + AW'(i);
        e_fev = 1'b1;
        if (e_err != '1) e_err = e_err + (AW+1)'(1);
      end
    end
  endfunction

  task automatic model_begin(input bit md, input logic [AW-1:0] b, input logic [AW:0] len,
                             input logic [DW-1:0] sd);
    if (op_valid) begin
      model_eval(32'h3fff_ffff);
      base_err = e_err; base_fev = e_fev; base_fea = e_fea; base_ab = e_ab;
    end
    op_valid = 1'b1;
    op_mode  = md;
    op_T     = cyc;
    op_N     = (int'(len) > DEPTH) ? DEPTH : int'(len);
    op_A     = 0;
    op_base  = b;
    op_seed  = sd;
    for (int i = 0; i < op_N; i++)
      mm[i] = md && (ram[b + AW'(i)] != sd + DW'(i));
  endtask

  always @(negedge clk) begin
    model_eval(cyc);
    check("busy", 32'(busy), 32'(e_busy));
    check("done", 32'(done), 32'(e_done));
    check("aborted", 32'(aborted), 32'(e_ab));
    check("m_clken", 32'(m_clken), 32'(e_clken));
    check("m_chipselect", 32'(m_chipselect), 32'(e_cs));
    check("m_write", 32'(m_write), 32'(e_wr));
    check("m_byteenable", 32'(m_byteenable), 32'h3);
    check("error_count", 32'(error_count), 32'(e_err));
    check("first_err_valid", 32'(first_err_valid), 32'(e_fev));
    if (e_fev) check("first_err_addr", 32'(first_err_addr), 32'(e_fea));
    if (e_cs) check("m_address", 32'(m_address), 32'(e_addr));
    if (e_wr) check("m_writedata", 32'(m_writedata), 32'(e_wdata));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input bit md, input logic [AW-1:0] b, input logic [AW:0] len,
                          input logic [DW-1:0] sd, output int t);
    mode = md; base_addr = b; length = len; seed = sd; start = 1'b1;
    model_begin(md, b, len, sd);
    t = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic poke_start(input bit md, input logic [AW-1:0] b, input logic [AW:0] len);
    mode = md; base_addr = b; length = len; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_abort();
    abort = 1'b1;
    if (op_valid && op_A == 0 && cyc > op_T && cyc <= win_end()) op_A = cyc;
    tick();
    abort = 1'b0;
  endtask

  task automatic corrupt(input logic [AW-1:0] a, input logic [DW-1:0] d);
    corrupt_addr = a; corrupt_data = d; corrupt_req = 1'b1;
    tick();
    corrupt_req = 1'b0;
  endtask

  task automatic wait_done(input int t, output int lat);
    int dc = -1;
    for (int k = 0; k < 3000; k++) begin
      if (done) begin
        dc = cyc;
        break;
      end
      tick();
    end
    if (dc < 0) check("done_timeout", 32'(cyc), 32'(t));
    lat = dc - t;
    tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    op_valid = 1'b0;
    base_err = '0; base_fev = 1'b0; base_fea = '0; base_ab = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'h0);
    check("mid_rst_cs", 32'(m_chipselect), 32'h0);
    check("mid_rst_addr", 32'(m_address), 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    int t, lat;
    repeat (3) tick();
    check("rst_addr", 32'(m_address), 32'h0);
    check("rst_wdata", 32'(m_writedata), 32'h0);
    check("rst_fea", 32'(first_err_addr), 32'h0);
    rst_n = 1'b1;
    tick();
    corrupt(11'h000, 16'hBEEF);

    // FILL across the top-of-RAM wrap
    start_op(1'b0, 11'h7FE, 12'd4, 16'hFFFE, t);
    wait_done(t, lat);
    check("fill_done_lat", 32'(lat), 32'd5);
    check("fill_err", 32'(error_count), 32'h0);
    check("ram_7fe", 32'(ram[11'h7FE]), 32'hFFFE);
    check("ram_7ff", 32'(ram[11'h7FF]), 32'hFFFF);
    check("ram_000", 32'(ram[11'h000]), 32'h0000);
    check("ram_001", 32'(ram[11'h001]), 32'h0001);

    // VERIFY the same window, clean
    start_op(1'b1, 11'h7FE, 12'd4, 16'hFFFE, t);
    wait_done(t, lat);
    check("verify_done_lat", 32'(lat), 32'(4 + RL + 1));
    check("verify_err", 32'(error_count), 32'h0);
    check("verify_fev", 32'(first_err_valid), 32'h0);

    // VERIFY with word 0x000 corrupted
    corrupt(11'h000, 16'h1234);
    start_op(1'b1, 11'h7FE, 12'd4, 16'hFFFE, t);
    wait_done(t, lat);
    check("bad_done_lat", 32'(lat), 32'(4 + RL + 1));
    check("bad_err", 32'(error_count), 32'h1);
    check("bad_fev", 32'(first_err_valid), 32'h1);
    check("bad_fea", 32'(first_err_addr), 32'h000);

    // Zero-length command
    start_op(1'b0, 11'h123, 12'd0, 16'h7777, t);
    wait_done(t, lat);
    check("zero_done_lat", 32'(lat), 32'd1);
    check("zero_err_cleared", 32'(error_count), 32'h0);

    // Over-length FILL is clamped to the whole RAM, wrapping once
    start_op(1'b0, 11'h005, 12'hFFF, 16'h0100, t);
    wait_done(t, lat);
    check("full_done_lat", 32'(lat), 32'd2049);
    check("full_ram_005", 32'(ram[11'h005]), 32'h0100);
    check("full_ram_7ff", 32'(ram[11'h7FF]), 32'h08FA);
    check("full_ram_004", 32'(ram[11'h004]), 32'h08FF);
    start_op(1'b1, 11'h005, 12'h800, 16'h0100, t);
    wait_done(t, lat);
    check("full_verify_lat", 32'(lat), 32'(2048 + RL + 1));
    check("full_verify_err", 32'(error_count), 32'h0);

    // Abort during VERIFY at offset 2 of 8; a start while busy is ignored
    start_op(1'b0, 11'h100, 12'd8, 16'hA000, t);
    wait_done(t, lat);
    corrupt(11'h102, 16'h0000);
    start_op(1'b1, 11'h100, 12'd8, 16'hA000, t);
    poke_start(1'b0, 11'h300, 12'd4);
    tick();
    pulse_abort();
    wait_done(t, lat);
    check("abort_done_lat", 32'(lat), 32'd4);
    check("abort_flag", 32'(aborted), 32'h1);
    check("abort_err", 32'(error_count), 32'h0);
    pulse_abort();
    tick();
    check("abort_held", 32'(aborted), 32'h1);

    // Reset in the middle of a FILL, then a normal run
    start_op(1'b0, 11'h200, 12'd16, 16'h4000, t);
    repeat (5) tick();
    do_reset();
    start_op(1'b0, 11'h200, 12'd16, 16'h5555, t);
    wait_done(t, lat);
    check("post_rst_fill_lat", 32'(lat), 32'd17);
    check("post_rst_ram_20f", 32'(ram[11'h20F]), 32'h5564);
    start_op(1'b1, 11'h200, 12'd16, 16'h5555, t);
    wait_done(t, lat);
    check("post_rst_verify_lat", 32'(lat), 32'(16 + RL + 1));
    check("post_rst_verify_err", 32'(error_count), 32'h0);

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/onchip_mem_pattern_master.md
Name: onchip_mem_pattern_master

Overview:
- Avalon-MM initiator that drives the s1 slave port of the 2K x 16 on-chip RAM (11-bit word address, 16-bit data, 2-bit byteenable, clken).
- Fills a window of the RAM with an incrementing pattern, or reads the window back and checks it against the same pattern.
- Reports an error count and the address of the first mismatch.
- Sits between the control/status logic and the RAM, for bring-up and built-in self-test.

Parameters:
- ADDR_W, 11, word address width (RAM depth 2^ADDR_W).
- DATA_W, 16, data width; byteenable width is DATA_W/8.
- READ_LATENCY, 1, cycles from read issue to readdata valid; legal values 1..3.

Ports:
- clk_clk  in  1  single clock; all logic is rising-edge.
- reset_reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle command strobe; sampled only in IDLE.
- mode  in  1  0 = FILL, 1 = VERIFY; latched on start.
- base_addr  in  ADDR_W  first word address; latched on start.
- length  in  ADDR_W+1  number of words; latched on start, clamped to 2^ADDR_W.
- seed  in  DATA_W  pattern for word 0; word i = seed+i mod 2^DATA_W.
- abort  in  1  stops the operation early.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle completion pulse.
- aborted  out  1  high with done if the operation was aborted; held until next start.
- error_count  out  ADDR_W+1  VERIFY mismatches; saturates at its maximum.
- first_err_valid  out  1  set on the first mismatch.
- first_err_addr  out  ADDR_W  address of the first mismatch.
- m_address  out  ADDR_W  to s1 address.
- m_clken  out  1  to s1 clken.
- m_chipselect  out  1  to s1 chipselect.
- m_write  out  1  to s1 write.
- m_writedata  out  DATA_W  to s1 writedata.
- m_byteenable  out  DATA_W/8  to s1 byteenable.
- m_readdata  in  DATA_W  from s1 readdata.

Behaviour:
- Reset (async assert, sync release): state IDLE. Outputs busy, done, aborted, first_err_valid, m_chipselect, m_write, m_clken = 0. Outputs error_count, first_err_addr, m_address, m_writedata = 0. m_byteenable = all ones.
- States: IDLE, ISSUE, DRAIN, FINISH.
- IDLE -> ISSUE when start=1 and length!=0. On that edge: latch mode/base/length/seed; clear error_count, first_err_valid, aborted.
- IDLE -> FINISH when start=1 and length=0. No memory access; done is seen the cycle after start.
- start outside IDLE is ignored.
- ISSUE: one access per cycle, offset i = 0..N-1.
  - m_address = (base+i) mod 2^ADDR_W; wraps 0x7FF -> 0x000.
  - m_chipselect=1; m_write = (mode==FILL); m_writedata = seed+i in FILL, don't-care in VERIFY.
  - Access for offset 0 is on the bus in the cycle after start (cycle T+1).
- ISSUE exit after offset N-1: FILL -> FINISH; VERIFY -> DRAIN.
- m_clken=1 in every non-IDLE state, 0 in IDLE.
- m_chipselect and m_write are 0 outside ISSUE.
- VERIFY data path:
  - A valid/expected/address pipeline of depth READ_LATENCY tracks each read.
  - Readdata for a read driven in cycle k is sampled at the end of cycle k+READ_LATENCY and compared to seed+i.
  - On mismatch, error_count increments (saturating). If first_err_valid=0, capture first_err_addr and set first_err_valid.
- DRAIN: no new accesses; wait until the pipeline is empty, then FINISH.
- FINISH: done=1 for exactly one cycle, busy=0 in that cycle, then IDLE.
- Timing from start in cycle T, N words:
  - FILL: done in cycle T+N+1.
  - VERIFY: done in cycle T+N+READ_LATENCY+1.
- abort=1 in ISSUE or DRAIN:
  - No further accesses from the next cycle.
  - Reads still in flight are discarded (not compared).
  - Go to FINISH; done pulses with aborted=1.
  - abort in IDLE/FINISH is ignored.
  - abort and start in the same IDLE cycle: start wins.
- Reset mid-operation: immediate return to reset values. A write beat may be cut off; no done pulse.
- length > 2^ADDR_W is clamped. length = 2^ADDR_W covers the whole RAM exactly once.

Test Plan:
- FILL base=0x7FE, length=4, seed=0xFFFE, start at T -> writes (7FE,FFFE),(7FF,FFFF),(000,0000),(001,0001) in T+1..T+4, byteenable=11, done at T+5, error_count=0.
- VERIFY same window against a RAM model (latency 1) -> 4 reads T+1..T+4, done at T+6, error_count=0, first_err_valid=0.
- Model word 0x000 corrupted to 0x1234, VERIFY -> error_count=1, first_err_addr=0x000; READ_LATENCY=2 build -> done at T+7.
- length=0 start -> no chipselect, done at T+1. length=0xFFF -> 2048 writes, wrapping once.
- abort during VERIFY at offset 2 of 8 -> no access after offset 2, in-flight read not counted, done with aborted=1. start while busy -> ignored.
- reset_reset_n low mid-FILL -> all outputs at reset values immediately, no done. Next start runs normally.
